stepper_stroke_driver: RTL
==========================

Name: stepper_stroke_driver

Overview:
Parametrised stepper-motor stroke sequencer, the successor to the single-purpose cut driver. It drives a 4-wire bipolar stepper through a programmable number of back-and-forth strokes, with selectable full-step or half-step drive, an optional dwell between strokes, and abort support. It sits between the kitchen-helper controller and the motor pins. It runs entirely in the system clock domain using an internal step-tick enable; no derived clock is generated.

Parameters:
STEP_TICKS, 500000, clk cycles per motor step (10 ms at 50 MHz); >=2
STEPS_PER_STROKE, 100, steps per stroke (90 deg full-step at 0.9 deg/step); 1..65535
STROKES, 2, strokes per run; direction reverses after each stroke; 1..255
DWELL_TICKS, 0, whole step periods of idle dwell between strokes; 0 = none

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
start_i  in  1  start request, sampled only in IDLE
abort_i  in  1  abort request, sampled every cycle
dir_i  in  1  first-stroke direction, sampled at start: 1 = phase index increments, 0 = decrements
half_i  in  1  drive mode, sampled at start: 1 = half-step, 0 = full-step (two-phase)
busy_o  out  1  high while a run is in progress (RUN or DWELL)
done_o  out  1  one-cycle pulse on normal completion
step_cnt_o  out  16  steps taken in the current stroke
stroke_cnt_o  out  8  completed strokes in the current run
signal_o  out  4  coil drive {B', A', B, A}, registered

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; signal_o=0000; busy_o=0; done_o=0; step_cnt_o=0; stroke_cnt_o=0; tick counter=0; phase index=0.
- Coil table by 3-bit phase index 0..7: 0011, 0010, 0110, 0100, 1100, 1000, 1001, 0001. Even indices are the two-phase full-step patterns.
- State IDLE: signal_o=0000. start_i=1 and abort_i=0 -> RUN on the next edge. At that edge: busy_o=1, counters cleared, dir/mode latched, and in full-step mode phase bit0 is cleared. signal_o becomes table[phase] on the same edge; this energise is not counted as a step.
- The phase index persists across runs and is cleared only by rst.
- Tick generation: the counter runs 0..STEP_TICKS-1 only in RUN/DWELL and is cleared on entry to RUN. A tick fires on the cycle the counter equals STEP_TICKS-1, so the first tick is STEP_TICKS cycles after RUN entry.
- RUN, on each tick: phase moves +/-1 (half-step) or +/-2 (full-step), mod 8, per the current direction. signal_o updates on the same edge, and step_cnt increments.
- Stroke end: the tick that makes step_cnt reach STEPS_PER_STROKE sets step_cnt=0, increments stroke_cnt and toggles direction.
  - If the new stroke_cnt equals STROKES -> DONE.
  - Else if DWELL_TICKS>0 -> DWELL.
  - Else stay in RUN.
- DWELL: holds the coil pattern, counts DWELL_TICKS ticks, then returns to RUN. The tick counter is not cleared.
- DONE: exactly one cycle with busy_o=0, done_o=1, and signal_o per the hold rule (see Optional Feature). Then IDLE. stroke_cnt_o holds STROKES until the next start.
- abort_i=1 in RUN/DWELL/DONE -> IDLE on the next edge: signal_o=0000, busy_o=0, no done_o, counters keep their values.
- abort_i with start_i in IDLE: abort wins, stay IDLE.
- start_i while busy is ignored (no restart, no queuing).
- rst mid-run overrides everything and gives the reset values on the next edge.
- Counter widths: 32-bit tick counter; step_cnt and stroke_cnt saturate-free because they never exceed their parameters.

Optional Feature:
Macro STEPPER_HOLD_EN.
- Defined: in DONE and IDLE after a completed run, signal_o holds the last energised pattern (holding torque). Abort and rst still force 0000.
- Undefined: DONE and IDLE drive 0000.

Test Plan:
- Reset: rst=1 for 3 cycles mid-run -> signal_o=0000, busy_o=0, done_o=0, step_cnt_o=0, stroke_cnt_o=0 on the first edge with rst=1.
- Full-step run: STEP_TICKS=4, STEPS_PER_STROKE=3, STROKES=2, DWELL_TICKS=0, dir_i=1, half_i=0, start at cycle 0.
  - signal_o sequence 0011 (cycle 1), then 0110, 1100, 1001 at cycles 5, 9, 13.
  - Then reverse: 1100, 0110, 0011 at cycles 17, 21, 25.
  - done_o=1 at cycle 26 only; busy_o=1 for cycles 1..25.
- Half-step with dir_i=0 from phase 0: 0011 -> 0001 -> 1001 -> 1000, one change every STEP_TICKS cycles.
- Dwell: DWELL_TICKS=2 with the full-step parameters above -> signal_o frozen for 8 extra cycles between strokes; done_o 8 cycles later than without dwell.
- Abort and start rules:
  - abort_i pulse after the 2nd step -> signal_o=0000 and busy_o=0 next cycle, no done_o, step_cnt_o=2 retained.
  - start_i while busy -> no effect.
  - start_i+abort_i in IDLE -> stays IDLE.
- STEPPER_HOLD_EN: after the full-step run completes, signal_o stays 0011 in IDLE when defined; 0000 when undefined.

Source files
------------

// File: rtl/stepper_stroke_driver.sv
// Back-and-forth stroke sequencer for a 4-wire bipolar stepper, full- or half-step drive.
// Optional holding torque after a completed run: define STEPPER_HOLD_EN.
module stepper_stroke_driver #(
  parameter int unsigned STEP_TICKS       = 500000,
  parameter int unsigned STEPS_PER_STROKE = 100,
  parameter int unsigned STROKES          = 2,
  parameter int unsigned DWELL_TICKS      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        dir_i,
  input  logic        half_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] step_cnt_o,
  output logic [7:0]  stroke_cnt_o,
  output logic [3:0]  signal_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] TICK_LAST  = 32'(STEP_TICKS - 1);
  localparam logic [15:0] STEP_LAST  = 16'(STEPS_PER_STROKE - 1);
  localparam logic [7:0]  STROKE_N   = 8'(STROKES);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_TICKS - 1);
  localparam logic        DWELL_ON   = (DWELL_TICKS != 32'd0);

  // Even indices are the two-phase full-step patterns.
  function automatic logic [3:0] coil(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b0011;
      3'd1:    pat = 4'b0010;
      3'd2:    pat = 4'b0110;
      3'd3:    pat = 4'b0100;
      3'd4:    pat = 4'b1100;
      3'd5:    pat = 4'b1000;
      3'd6:    pat = 4'b1001;
      3'd7:    pat = 4'b0001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] dwell_q, dwell_d;
  logic [2:0]  phase_q, phase_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  stroke_q, stroke_d;
  logic        dir_q, dir_d;
  logic        half_q, half_d;
  logic [3:0]  signal_q, signal_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tick_s;
  logic [2:0]  inc_s;
  logic [2:0]  start_phase_s;
  logic [2:0]  next_phase_s;
  logic [3:0]  idle_sig_s;
  logic [7:0]  stroke_inc_s;

  // Step-tick, phase-advance and idle-pattern helpers.
  always_comb begin
    tick_s        = (tick_q == TICK_LAST);
    inc_s         = half_q ? 3'd1 : 3'd2;
    start_phase_s = half_i ? phase_q : {phase_q[2:1], 1'b0};
    next_phase_s  = dir_q ? (phase_q + inc_s) : (phase_q - inc_s);
    stroke_inc_s  = stroke_q + 8'd1;
`ifdef STEPPER_HOLD_EN
    idle_sig_s    = signal_q;
`else
    idle_sig_s    = 4'b0000;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    dwell_d  = dwell_q;
    phase_d  = phase_q;
    step_d   = step_q;
    stroke_d = stroke_q;
    dir_d    = dir_q;
    half_d   = half_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        signal_d = idle_sig_s;
        if (start_i && !abort_i) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          tick_d   = 32'd0;
          dwell_d  = 32'd0;
          step_d   = 16'd0;
          stroke_d = 8'd0;
          dir_d    = dir_i;
          half_d   = half_i;
          phase_d  = start_phase_s;
          signal_d = coil(start_phase_s);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        tick_d = tick_s ? 32'd0 : (tick_q + 32'd1);
        if (abort_i) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          signal_d = 4'b0000;
        end else if (stroke_q == STROKE_N) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          signal_d = idle_sig_s;
        end else if (tick_s) begin
          phase_d  = next_phase_s;
          signal_d = coil(next_phase_s);
          if (step_q == STEP_LAST) begin
            step_d   = 16'd0;
            stroke_d = stroke_inc_s;
            dir_d    = ~dir_q;
            // The last stroke falls through to DONE on the following cycle.
            if ((stroke_inc_s != STROKE_N) && DWELL_ON) begin
              state_d = S_DWELL;
              dwell_d = 32'd0;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            step_d = step_q + 16'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end

      S_DWELL: begin
        tick_d = tick_s ? 32'd0 : (tick_q + 32'd1);
        if (abort_i) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          signal_d = 4'b0000;
        end else if (tick_s) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = S_RUN;
            dwell_d = 32'd0;
          end else begin
            dwell_d = dwell_q + 32'd1;
          end
        end else begin
          state_d = S_DWELL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort_i) begin
          signal_d = 4'b0000;
        end else begin
          signal_d = idle_sig_s;
        end
      end

      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        signal_d = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tick_q   <= 32'd0;
      dwell_q  <= 32'd0;
      phase_q  <= 3'd0;
      step_q   <= 16'd0;
      stroke_q <= 8'd0;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      signal_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      stroke_q <= stroke_d;
      dir_q    <= dir_d;
      half_q   <= half_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign step_cnt_o   = step_q;
  assign stroke_cnt_o = stroke_q;
  assign signal_o     = signal_q;

endmodule
